// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared states, grant encoding and default widths for data_mem_arbiter
package data_mem_arb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LANES  = 4;
    localparam int DEF_CNT_W  = 19;

    typedef enum logic [1:0] {IDLE, S_ISSUE, V_ISSUE, DONE} arb_state_t;

    localparam logic GRANT_S = 1'b0;
    localparam logic GRANT_V = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter that adds a small increment each cycle and sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 19,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W:0] sum;

    assign sum = {1'b0, count} + (CNT_W+1)'(inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-memory port between scalar and burst vector load/store paths
// Performance counters exist only when DATA_MEM_ARB_PERF_EN is defined; otherwise they read 0.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_req_valid,
    input  logic                    s_req_we,
    input  logic [ADDR_W-1:0]       s_req_addr,
    input  logic [DATA_W-1:0]       s_req_wdata,
    output logic                    s_req_ready,
    output logic                    s_rsp_valid,
    output logic [DATA_W-1:0]       s_rsp_rdata,
    input  logic                    v_req_valid,
    input  logic                    v_req_we,
    input  logic [ADDR_W-1:0]       v_req_addr,
    input  logic [LANES*DATA_W-1:0] v_req_wdata,
    output logic                    v_req_ready,
    output logic                    v_rsp_valid,
    output logic [LANES*DATA_W-1:0] v_rsp_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic [CNT_W-1:0]        wait_count,
    output logic [CNT_W-1:0]        s_access_count,
    output logic [CNT_W-1:0]        v_access_count
);
    localparam int BW = $clog2(LANES);

    arb_state_t                   state, state_nx;
    logic [BW-1:0]                beat;
    logic                         last_grant, we_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [LANES-1:0][DATA_W-1:0] wdata_q, lane_q, v_rdata_q, v_done;
    logic [DATA_W-1:0]            s_rdata_q;
    logic                         accepting, grant_s, grant_v, s_wait, v_wait;

    // rst_n gates the handshake so every output is 0 while reset is held
    assign accepting   = rst_n && (state == IDLE || state == DONE);
    assign grant_s     = accepting && s_req_valid && (!v_req_valid || last_grant == GRANT_V);
    assign grant_v     = accepting && v_req_valid && (!s_req_valid || last_grant == GRANT_S);
    assign s_req_ready = grant_s;
    assign v_req_ready = grant_v;
    assign s_wait      = rst_n && s_req_valid && !grant_s;
    assign v_wait      = rst_n && v_req_valid && !grant_v;
    assign busy        = mem_en || s_wait || v_wait;
    assign mem_we      = mem_en && we_q;

    always_comb begin
        state_nx    = grant_s ? S_ISSUE : grant_v ? V_ISSUE : IDLE;
        mem_en      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        s_rsp_valid = 1'b0;
        v_rsp_valid = 1'b0;
        if (state == S_ISSUE) begin
            state_nx  = DONE;
            mem_en    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q[0];
        end
        if (state == V_ISSUE) begin
            state_nx  = (beat == BW'(LANES-1)) ? DONE : V_ISSUE;
            mem_en    = 1'b1;
            mem_addr  = addr_q + ADDR_W'(beat);
            mem_wdata = wdata_q[beat];
        end
        if (state == DONE) begin
            s_rsp_valid = last_grant == GRANT_S;
            v_rsp_valid = last_grant == GRANT_V;
        end
    end

    // the final lane arrives on mem_rdata during DONE, so it bypasses the capture buffer
    always_comb begin
        v_done           = lane_q;
        v_done[LANES-1]  = mem_rdata;
    end

    assign s_rsp_rdata = (s_rsp_valid && !we_q) ? mem_rdata : s_rdata_q;
    assign v_rsp_rdata = (v_rsp_valid && !we_q) ? v_done : v_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat       <= '0;
            last_grant <= GRANT_S;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            s_rdata_q  <= '0;
            v_rdata_q  <= '0;
        end else begin
            beat <= (state == V_ISSUE) ? beat + 1'b1 : '0;
            if (grant_s) begin
                last_grant <= GRANT_S;
                we_q       <= s_req_we;
                addr_q     <= s_req_addr;
                wdata_q[0] <= s_req_wdata;
            end
            if (grant_v) begin
                last_grant <= GRANT_V;
                we_q       <= v_req_we;
                addr_q     <= v_req_addr;
                wdata_q    <= v_req_wdata;
            end
            if (state == V_ISSUE && !we_q && beat != '0) lane_q[beat - 1'b1] <= mem_rdata;
            if (s_rsp_valid && !we_q) s_rdata_q <= mem_rdata;
            if (v_rsp_valid && !we_q) v_rdata_q <= v_done;
        end
    end

`ifdef DATA_MEM_ARB_PERF_EN
    sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ({1'b0, s_wait} + {1'b0, v_wait}),
        .count (wait_count)
    );
    sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_s_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_s),
        .count (s_access_count)
    );
    sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_v),
        .count (v_access_count)
    );
`else
    assign wait_count     = '0;
    assign s_access_count = '0;
    assign v_access_count = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized and directed bench for data_mem_arbiter against a transaction-timeline model
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int L  = 4;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic s_req_valid, s_req_we, s_req_ready, s_rsp_valid;
    logic [AW-1:0] s_req_addr;
    logic [DW-1:0] s_req_wdata, s_rsp_rdata;
    logic v_req_valid, v_req_we, v_req_ready, v_rsp_valid;
    logic [AW-1:0] v_req_addr;
    logic [L*DW-1:0] v_req_wdata, v_rsp_rdata;
    logic mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] wait_count, s_access_count, v_access_count;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_we(s_req_we), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_req_ready(s_req_ready),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .v_req_valid(v_req_valid), .v_req_we(v_req_we), .v_req_addr(v_req_addr),
        .v_req_wdata(v_req_wdata), .v_req_ready(v_req_ready),
        .v_rsp_valid(v_rsp_valid), .v_rsp_rdata(v_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .wait_count(wait_count), .s_access_count(s_access_count),
        .v_access_count(v_access_count)
    );

    // memory the DUT talks to, plus an independent copy the model updates
    logic [DW-1:0] bmem [0:65535];
    logic [DW-1:0] rmem [0:65535];
    logic [DW-1:0] rd_reg = '0;
    assign mem_rdata = rd_reg;
    always @(posedge clk) if (mem_en) begin
        if (mem_we) bmem[mem_addr] <= mem_wdata;
        else        rd_reg <= bmem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 2) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3)) : AW'($urandom_range(0, 31));
    endfunction

    // model: each accepted request owns the port for a fixed window after its accept cycle
    int cyc = 0, next_acc = 0, acc_c = 0;
    bit lg = 0, cur_on = 0, cur_v = 0, cur_we = 0;
    logic [AW-1:0] cur_addr;
    logic [L-1:0][DW-1:0] cur_wd, pend;
    logic [DW-1:0] e_srd = '0;
    logic [L*DW-1:0] e_vrd = '0;
    int e_wait = 0, e_sacc = 0, e_vacc = 0;

    always @(negedge clk) begin : model
        bit gs, gv, en, sw, vw, sr, vr;
        int len, k;
        logic [AW-1:0] a;
        cyc++;
        if (!rst_n) begin
            chk("rst_s_ready", s_req_ready, 0);
            chk("rst_v_ready", v_req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_s_rsp", s_rsp_valid, 0);
            chk("rst_v_rsp", v_rsp_valid, 0);
            chk("rst_s_rdata", s_rsp_rdata, 0);
            chk("rst_v_rdata", v_rsp_rdata, 0);
            chk("rst_wait_cnt", wait_count, 0);
            next_acc = 0; lg = 0; cur_on = 0;
            e_srd = '0; e_vrd = '0; e_wait = 0; e_sacc = 0; e_vacc = 0;
        end else begin
            len = cur_v ? L : 1;
            gs = cyc >= next_acc && s_req_valid && (!v_req_valid || lg);
            gv = cyc >= next_acc && v_req_valid && (!s_req_valid || !lg);
            en = cur_on && cyc > acc_c && cyc <= acc_c + len;
            sw = s_req_valid && !gs;
            vw = v_req_valid && !gv;
            chk("s_ready", s_req_ready, gs);
            chk("v_ready", v_req_ready, gv);
            chk("mem_en", mem_en, en);
            chk("busy", busy, en || sw || vw);
            if (en) begin
                k = cyc - acc_c - 1;
                a = cur_addr + AW'(k);
                chk("mem_addr", mem_addr, a);
                chk("mem_we", mem_we, cur_we);
                if (cur_we) begin
                    chk("mem_wdata", mem_wdata, cur_wd[k]);
                    rmem[a] = cur_wd[k];
                end else pend[k] = rmem[a];
            end
            sr = cur_on && !cur_v && cyc == acc_c + len + 1;
            vr = cur_on && cur_v && cyc == acc_c + len + 1;
            if (sr && !cur_we) e_srd = pend[0];
            if (vr && !cur_we) e_vrd = pend;
            if (sr || vr) cur_on = 0;
            chk("s_rsp_valid", s_rsp_valid, sr);
            chk("v_rsp_valid", v_rsp_valid, vr);
            chk("s_rsp_rdata", s_rsp_rdata, e_srd);
            chk("v_rsp_rdata", v_rsp_rdata, e_vrd);
`ifdef DATA_MEM_ARB_PERF_EN
            chk("wait_count", wait_count, e_wait);
            chk("s_access_count", s_access_count, e_sacc);
            chk("v_access_count", v_access_count, e_vacc);
`else
            chk("wait_count_off", wait_count, 0);
            chk("s_access_count_off", s_access_count, 0);
            chk("v_access_count_off", v_access_count, 0);
`endif
            e_wait = (e_wait + int'(sw) + int'(vw) > MAXC) ? MAXC : e_wait + int'(sw) + int'(vw);
            e_sacc = (e_sacc + int'(gs) > MAXC) ? MAXC : e_sacc + int'(gs);
            e_vacc = (e_vacc + int'(gv) > MAXC) ? MAXC : e_vacc + int'(gv);
            if (gs) begin
                cur_on = 1; cur_v = 0; cur_we = s_req_we; cur_addr = s_req_addr;
                cur_wd[0] = s_req_wdata; acc_c = cyc; next_acc = cyc + 2; lg = 0;
            end
            if (gv) begin
                cur_on = 1; cur_v = 1; cur_we = v_req_we; cur_addr = v_req_addr;
                cur_wd = v_req_wdata; acc_c = cyc; next_acc = cyc + L + 1; lg = 1;
            end
        end
    end

    // both request tasks start at posedge+1 and return at posedge+1 of the cycle after accept
    task automatic s_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        s_req_valid = 1; s_req_we = we; s_req_addr = a; s_req_wdata = d;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = s_req_valid && s_req_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("s_accept_in_time", ok, 1);
        @(posedge clk); #1;
        s_req_valid = 0;
    endtask

    task automatic v_issue(input bit we, input logic [AW-1:0] a, input logic [L*DW-1:0] d);
        bit ok = 0;
        v_req_valid = 1; v_req_we = we; v_req_addr = a; v_req_wdata = d;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = v_req_valid && v_req_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("v_accept_in_time", ok, 1);
        @(posedge clk); #1;
        v_req_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        bit ok, sf, vf;
        logic [AW-1:0] a;
        int n;
        rst_n = 0;
        s_req_valid = 0; s_req_we = 0; s_req_addr = '0; s_req_wdata = '0;
        v_req_valid = 0; v_req_we = 0; v_req_addr = '0; v_req_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            bmem[i] = init_val(i);
            rmem[i] = init_val(i);
        end
        bmem[16'h0010] = 32'hDEADBEEF; rmem[16'h0010] = 32'hDEADBEEF;
        bmem[16'hFFFE] = 32'hA0A0A0A0; rmem[16'hFFFE] = 32'hA0A0A0A0;
        bmem[16'hFFFF] = 32'hA1A1A1A1; rmem[16'hFFFF] = 32'hA1A1A1A1;
        bmem[16'h0000] = 32'hA2A2A2A2; rmem[16'h0000] = 32'hA2A2A2A2;
        bmem[16'h0001] = 32'hA3A3A3A3; rmem[16'h0001] = 32'hA3A3A3A3;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        s_issue(0, 16'h0010, '0);
        @(negedge clk);
        chk("scalar_rd_en_t1", mem_en, 1);
        chk("scalar_rd_addr_t1", mem_addr, 16'h0010);
        @(negedge clk);
        chk("scalar_rsp_t2", s_rsp_valid, 1);
        chk("scalar_rdata_t2", s_rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("scalar_busy_after", busy, 0);

        v_issue(1, 16'h0100, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk("vwr_addr", mem_addr, 16'h0100 + k);
            chk("vwr_data", mem_wdata, k + 1);
        end
        @(negedge clk);
        chk("vwr_rsp_t5", v_rsp_valid, 1);
        chk("vwr_mem_0103", bmem[16'h0103], 4);

        do_reset();
        s_req_valid = 1; s_req_we = 0; s_req_addr = 16'h0020;
        v_req_valid = 1; v_req_we = 0; v_req_addr = 16'h0030;
        @(negedge clk);
        chk("conflict1_v_ready", v_req_ready, 1);
        chk("conflict1_s_ready", s_req_ready, 0);
        @(posedge clk); #1;
        v_req_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        v_req_valid = 1; v_req_we = 1; v_req_addr = 16'h0040; v_req_wdata = {4{32'h5A5A0000}};
        @(negedge clk);
        chk("conflict2_s_ready", s_req_ready, 1);
        chk("conflict2_v_ready", v_req_ready, 0);
`ifdef DATA_MEM_ARB_PERF_EN
        chk("conflict_wait_count", wait_count, L + 1);
`else
        chk("conflict_wait_count_off", wait_count, 0);
`endif
        @(posedge clk); #1;
        s_req_valid = 0;
        ok = 0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = v_req_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("v_after_scalar_delay", n, 2);
        @(posedge clk); #1;
        v_req_valid = 0;
        repeat (8) @(posedge clk);
        #1;

        v_issue(0, 16'hFFFE, '0);
        a = 16'hFFFE;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk("vrd_wrap_addr", mem_addr, a);
            a = a + 1'b1;
        end
        @(negedge clk);
        chk("vrd_wrap_rsp", v_rsp_valid, 1);
        chk("vrd_wrap_data", v_rsp_rdata, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
        @(posedge clk); #1;

        v_issue(0, 16'h0200, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_v_rsp", v_rsp_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_strobe", mem_en, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        s_issue(0, 16'h0202, '0);
        @(negedge clk);
        @(negedge clk);
        chk("postrst_s_rsp", s_rsp_valid, 1);
        chk("postrst_s_rdata", s_rsp_rdata, init_val(16'h0202));
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sf = s_req_valid && s_req_ready;
            vf = v_req_valid && v_req_ready;
            @(posedge clk); #1;
            rst_n = (c % 700 != 699);
            if (sf) s_req_valid = 0;
            if (vf) v_req_valid = 0;
            if (!s_req_valid && $urandom_range(0, 2) == 0) begin
                s_req_valid = 1; s_req_we = 1'($urandom); s_req_addr = rand_addr(); s_req_wdata = $urandom;
            end
            if (!v_req_valid && $urandom_range(0, 3) == 0) begin
                v_req_valid = 1; v_req_we = 1'($urandom); v_req_addr = rand_addr();
                v_req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        rst_n = 1;
        s_req_valid = 0; v_req_valid = 0;
        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
